// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter command sequencer.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STEP     = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_CLEAR    = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_e;

    localparam logic OP_UP   = 1'b1;
    localparam logic OP_DOWN = 1'b0;

    // A step in direction dir is blocked when the counter already sits at that end.
    function automatic logic at_limit(input logic dir, input logic z, input logic m);
        return (dir == OP_UP) ? m : z;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous button inputs.
module btn_sync #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability filter stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Button front-end: turns raw up/down buttons into single-cycle counter commands
// with step, auto-repeat, clear-on-both and saturation at the counter limits.
module counter_cmd_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter int unsigned TMR_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic u,
    input  logic d,
    input  logic z,
    input  logic m,
    output logic op,
    output logic c_ld,
    output logic c_clr,
    output logic busy
);

    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LD  = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_0   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_1   = {{(TMR_W-1){1'b0}}, 1'b1};

    logic [1:0]       btn_sync_s;
    logic             us_s;
    logic             ds_s;
    logic             sel_s;
    logic             other_s;
    logic             fire_s;

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             op_q, op_d;
    logic             c_ld_q, c_ld_d;
    logic             c_clr_q, c_clr_d;
    logic             busy_q, busy_d;

    btn_sync #(.WIDTH(2)) u_btn_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i ({u, d}),
        .sync_o  (btn_sync_s)
    );

    assign us_s    = btn_sync_s[1];
    assign ds_s    = btn_sync_s[0];
    assign sel_s   = (dir_q == OP_UP) ? us_s : ds_s;
    assign other_s = (dir_q == OP_UP) ? ds_s : us_s;

    // State, timer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= OP_DOWN;
            tmr_q   <= TMR_0;
            op_q    <= 1'b0;
            c_ld_q  <= 1'b0;
            c_clr_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            op_q    <= op_d;
            c_ld_q  <= c_ld_d;
            c_clr_q <= c_clr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tmr_d   = tmr_q;
        op_d    = op_q;
        c_ld_d  = 1'b0;
        c_clr_d = 1'b0;
        fire_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (us_s && ds_s) begin
                    state_d = ST_CLEAR;
                end else if (us_s) begin
                    state_d = ST_STEP;
                    dir_d   = OP_UP;
                end else if (ds_s) begin
                    state_d = ST_STEP;
                    dir_d   = OP_DOWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                fire_s  = 1'b1;
                tmr_d   = HOLD_LD;
                state_d = ST_HOLD;
            end
            // Hold expiry drops straight into a repeat step; later steps are REPEAT_CYCLES apart.
            ST_HOLD: begin
                if (!sel_s) begin
                    state_d = ST_IDLE;
                end else if (other_s) begin
                    state_d = ST_CLEAR;
                end else if (tmr_q == TMR_0) begin
                    state_d = ST_REPEAT;
                    tmr_d   = TMR_0;
                end else begin
                    tmr_d = tmr_q - TMR_1;
                end
            end
            ST_REPEAT: begin
                if (!sel_s) begin
                    state_d = ST_IDLE;
                end else if (other_s) begin
                    state_d = ST_CLEAR;
                end else if (tmr_q == TMR_0) begin
                    fire_s = 1'b1;
                    tmr_d  = REP_LD;
                end else begin
                    tmr_d = tmr_q - TMR_1;
                end
            end
            ST_CLEAR: begin
                c_clr_d = 1'b1;
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!us_s && !ds_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A saturated step keeps its timing but drives neither c_ld nor op.
        if (fire_s && !at_limit(dir_q, z, m)) begin
            c_ld_d = 1'b1;
            op_d   = dir_q;
        end else begin
            c_ld_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign op    = op_q;
    assign c_ld  = c_ld_q;
    assign c_clr = c_clr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer with a behavioural 16-bit datapath and a strobe scoreboard.
module tb_counter_cmd_sequencer;

    typedef struct {
        int   cyc;
        logic clr;
        logic op;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        u;
    logic        d;
    logic        z;
    logic        m;
    logic        op;
    logic        c_ld;
    logic        c_clr;
    logic        busy;

    logic [15:0] cnt;
    logic        dp_load;
    logic [15:0] dp_val;
    logic [15:0] mv;
    logic        prev_op;
    int          cyc_cnt;
    int          checks;
    int          errors;
    ev_t         exp_q[$];

    counter_cmd_sequencer #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .TMR_W         (8)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .u     (u),
        .d     (d),
        .z     (z),
        .m     (m),
        .op    (op),
        .c_ld  (c_ld),
        .c_clr (c_clr),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural counter datapath.
    always @(posedge clk) begin
        if (dp_load)
            cnt <= dp_val;
        else if (c_ld)
            cnt <= op ? cnt + 16'd1 : cnt - 16'd1;
        else if (c_clr)
            cnt <= 16'd0;
    end
    assign z = (cnt == 16'd0);
    assign m = (cnt == 16'hFFFF);

    task automatic set_count(input logic [15:0] v);
        @(negedge clk);
        dp_load = 1'b1;
        dp_val  = v;
        @(negedge clk);
        dp_load = 1'b0;
        mv      = v;
    endtask

    // Push expected steps: first at first_e, repeats from first_e+9 every 4 while the button is seen held.
    task automatic predict(input logic dir, input int first_e, input int last_us, input int cutoff);
        int e;
        e = first_e;
        while (e <= cutoff && (e == first_e || e <= last_us)) begin
            if (dir ? (mv != 16'hFFFF) : (mv != 16'd0)) begin
                mv = dir ? mv + 16'd1 : mv - 16'd1;
                exp_q.push_back('{cyc: e, clr: 1'b0, op: dir});
            end
            e = (e == first_e) ? first_e + 9 : e + 4;
        end
    endtask

    // Advance n cycles, popping the scoreboard on every strobe.
    task automatic observe(input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst) begin
                if (c_ld || c_clr) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL strobe_unexpected: cyc=%0d c_ld=%b c_clr=%b op=%b, required no strobe",
                                 cyc_cnt, c_ld, c_clr, op);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc_cnt || e.clr !== c_clr || e.clr === c_ld || (c_ld && op !== e.op)) begin
                            errors++;
                            $display("FAIL strobe_match: got cyc=%0d c_ld=%b c_clr=%b op=%b, required cyc=%0d clr=%b op=%b",
                                     cyc_cnt, c_ld, c_clr, op, e.cyc, e.clr, e.op);
                        end
                    end
                end
                checks++;
                if (!c_ld && op !== prev_op) begin
                    errors++;
                    $display("FAIL op_hold: cyc=%0d op=%b without c_ld, required %b", cyc_cnt, op, prev_op);
                end
                prev_op = op;
            end else begin
                prev_op = 1'b0;
            end
        end
    endtask

    task automatic end_checks(input string name, input logic [15:0] want_cnt);
        observe(8);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d strobes never seen, first due cyc=%0d, required 0 pending",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
        checks++;
        if (cnt !== want_cnt) begin
            errors++;
            $display("FAIL %s_count: got %h, required %h", name, cnt, want_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_idle: got %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_count(16'd0);
        #1;
        checks++;
        if ({op, c_ld, c_clr, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got op/ld/clr/busy=%b, required 0000", {op, c_ld, c_clr, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        prev_op = 1'b0;
        end_checks("reset", 16'd0);
    endtask

    // Drive one button for h cycles starting now (at a negedge).
    task automatic press(input logic dir, input int h, input int tail);
        int c;
        c = cyc_cnt;
        if (dir) u = 1'b1; else d = 1'b1;
        predict(dir, c + 4, c + h + 2, c + h + 100);
        observe(h);
        u = 1'b0;
        d = 1'b0;
        observe(tail);
    endtask

    task automatic test_single_up();
        set_count(16'd5);
        press(1'b1, 3, 10);
        end_checks("single_up", 16'd6);
    endtask

    task automatic test_hold_up();
        set_count(16'd0);
        press(1'b1, 30, 6);
        end_checks("hold_up", 16'd6);
    endtask

    task automatic test_down_zero();
        set_count(16'd0);
        d = 1'b1;
        observe(10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL down_zero_busy: got %b, required 1", busy);
        end
        observe(10);
        d = 1'b0;
        end_checks("down_zero", 16'd0);
    endtask

    task automatic test_up_max();
        set_count(16'hFFFE);
        press(1'b1, 25, 6);
        end_checks("up_max", 16'hFFFF);
    endtask

    task automatic test_clear();
        int c;
        set_count(16'd1234);
        c = cyc_cnt;
        u = 1'b1;
        d = 1'b1;
        exp_q.push_back('{cyc: c + 4, clr: 1'b1, op: 1'b0});
        observe(15);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_wait_busy: got %b, required 1", busy);
        end
        u = 1'b0;
        d = 1'b0;
        end_checks("clear", 16'd0);
    endtask

    task automatic test_back_to_back();
        int c;
        set_count(16'd50);
        c = cyc_cnt;
        u = 1'b1;
        predict(1'b1, c + 4, c + 7, c + 7);
        observe(5);
        c = cyc_cnt;
        u = 1'b0;
        d = 1'b1;
        predict(1'b0, c + 5, c + 7, c + 7);
        observe(5);
        d = 1'b0;
        end_checks("dir_change", 16'd50);
    endtask

    task automatic test_reset_mid_repeat();
        int c;
        set_count(16'd100);
        c = cyc_cnt;
        u = 1'b1;
        predict(1'b1, c + 4, c + 1000, c + 20);
        observe(20);
        rst = 1'b1;
        #1;
        checks++;
        if ({op, c_ld, c_clr, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_outputs: got op/ld/clr/busy=%b, required 0000", {op, c_ld, c_clr, busy});
        end
        observe(2);
        c = cyc_cnt;
        rst = 1'b0;
        predict(1'b1, c + 4, c + 5, c + 1000);
        observe(3);
        u = 1'b0;
        observe(10);
        end_checks("reset_mid", 16'd104);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        u       = 1'b0;
        d       = 1'b0;
        rst     = 1'b1;
        dp_load = 1'b0;
        dp_val  = 16'd0;
        mv      = 16'd0;
        prev_op = 1'b0;
        test_reset();
        test_single_up();
        test_hold_up();
        test_down_zero();
        test_up_max();
        test_clear();
        test_back_to_back();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
